// File: rtl/alu_control_mc.sv
// ALU control decoder with a counter-driven FSM for multi-cycle mul/div/rem.
// Single-cycle ops decode combinationally; multi-cycle ops stall for a fixed latency and then pulse Done.
module alu_control_mc #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid,
    input  logic [1:0]        Aluop,
    input  logic [5:0]        Func,
    output logic [CTRL_W-1:0] Alucontrol,
    output logic              MulDiv,
    output logic              Stall,
    output logic              Done,
    output logic              Illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_REM = 4'b1010;

    // Counter is loaded with LAT-1 so that RUN lasts exactly LAT cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CTRL_W-1:0] op_q, op_nxt;

    logic [3:0]        dec_code;
    logic              dec_multi;
    logic              dec_bad;
    logic              accept;
    logic [CNT_W-1:0]  lat_load;

    always_comb begin
        dec_code  = OP_ADD;
        dec_multi = 1'b0;
        dec_bad   = 1'b0;
        case (Aluop)
            2'b11: dec_code = OP_ADD;
            2'b01: dec_code = OP_SUB;
            2'b10: dec_code = Func[3:0];
            default: begin
                case (Func)
                    6'd0: dec_code = OP_ADD;
                    6'd1: dec_code = OP_SUB;
                    6'd2: dec_code = OP_AND;
                    6'd3: dec_code = OP_OR;
                    6'd4: dec_code = OP_SLT;
                    6'd5: dec_code = OP_NOR;
                    6'd6: begin
                        dec_code  = OP_MUL;
                        dec_multi = 1'b1;
                    end
                    6'd7: begin
                        dec_code  = OP_DIV;
                        dec_multi = 1'b1;
                    end
                    6'd8: begin
                        dec_code  = OP_REM;
                        dec_multi = 1'b1;
                    end
                    default: begin
                        dec_code = OP_ADD;
                        dec_bad  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign accept   = Valid & dec_multi;
    assign lat_load = (dec_code == OP_MUL) ? MUL_LOAD : DIV_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        Alucontrol = CTRL_W'(dec_code);
        MulDiv     = 1'b0;
        Stall      = 1'b0;
        Done       = 1'b0;
        Illegal    = 1'b0;
        case (state)
            IDLE, DONE: begin
                Illegal = Valid & dec_bad;
                if (state == DONE) begin
                    Done       = 1'b1;
                    MulDiv     = 1'b1;
                    Alucontrol = op_q;
                    state_nxt  = IDLE;
                end
                // DONE accepts a new multi-cycle op exactly like IDLE does.
                if (accept) begin
                    Stall     = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = lat_load;
                    op_nxt    = CTRL_W'(dec_code);
                end
            end
            RUN: begin
                Alucontrol = op_q;
                MulDiv     = 1'b1;
                Stall      = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
